// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
// The misalign field exists only when EX_MEM_MISALIGN_CHK_EN is defined.
package ex_mem_pkg;

   localparam int unsigned EX_XLEN = 32;
   localparam int unsigned EX_REGW = 5;

   typedef enum logic [1:0] {
      SEL_ALU   = 2'b00,
      SEL_SHIFT = 2'b01,
      SEL_PC4   = 2'b10
   } result_sel_e;

   localparam logic [1:0] F3_BYTE = 2'b00;
   localparam logic [1:0] F3_HALF = 2'b01;
   localparam logic [1:0] F3_WORD = 2'b10;

   typedef struct packed {
      logic [EX_XLEN-1:0] result;
      logic [EX_XLEN-1:0] wdata;
      logic [EX_REGW-1:0] rd;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic [2:0]         funct3;
`ifdef EX_MEM_MISALIGN_CHK_EN
      logic               misalign;
`endif
   } ex_mem_payload_t;

   // Address alignment check for a given access size; bytes are always aligned.
   function automatic logic misalign_chk(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         F3_BYTE: bad = 1'b0;
         F3_HALF: bad = addr_lo[0];
         F3_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ex_mem_stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (main + skid) with synchronous flush.
// in_ready_o depends only on registered state.
module skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_xfer;

   assign in_ready_o  = ~skid_valid_q;
   assign in_xfer     = in_valid_i & ~skid_valid_q;
   assign out_valid_o = main_valid_q;
   assign out_data_o  = main_q;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush_i) begin
         // Payload is left stale; only the valid bits matter after a squash.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_ready_i) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_xfer) begin
            main_d       = in_data_i;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_d       = in_data_i;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: result select, payload registration via skid buffer, forwarding.
// Optional out_misalign port when EX_MEM_MISALIGN_CHK_EN is defined.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int unsigned XLEN = EX_XLEN,
   parameter int unsigned REGW = EX_REGW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   input  logic [XLEN-1:0] shift_y,
   input  logic [XLEN-1:0] alu_y,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [1:0]      result_sel,
   input  logic [XLEN-1:0] wdata,
   input  logic [REGW-1:0] rd,
   input  logic            regwrite,
   input  logic            memread,
   input  logic            memwrite,
   input  logic [2:0]      funct3,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [XLEN-1:0] out_wdata,
   output logic [REGW-1:0] out_rd,
   output logic            out_regwrite,
   output logic            out_memread,
   output logic            out_memwrite,
   output logic [2:0]      out_funct3,
   output logic            fwd_en,
   output logic [REGW-1:0] fwd_rd,
`ifdef EX_MEM_MISALIGN_CHK_EN
   output logic            out_misalign,
`endif
   output logic [XLEN-1:0] fwd_data
);

   localparam int unsigned PW = $bits(ex_mem_payload_t);

   ex_mem_payload_t in_pl;
   ex_mem_payload_t out_pl;
   logic [XLEN-1:0] result_c;

   // Reserved select code 11 falls back to the ALU result.
   always_comb begin
      result_c = alu_y;
      case (result_sel_e'(result_sel))
         SEL_ALU:   result_c = alu_y;
         SEL_SHIFT: result_c = shift_y;
         SEL_PC4:   result_c = pc_plus4;
         default:   result_c = alu_y;
      endcase
   end

   always_comb begin
      in_pl          = '0;
      in_pl.result   = EX_XLEN'(result_c);
      in_pl.wdata    = EX_XLEN'(wdata);
      in_pl.rd       = EX_REGW'(rd);
      in_pl.regwrite = regwrite;
      in_pl.memread  = memread;
      in_pl.memwrite = memwrite;
      in_pl.funct3   = funct3;
`ifdef EX_MEM_MISALIGN_CHK_EN
      in_pl.misalign = (memread | memwrite) & misalign_chk(funct3[1:0], alu_y[1:0]);
`endif
   end

   skid_buf #(
      .W (PW)
   ) u_skid (
      .clk_i       (clk),
      .reset_i     (reset),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_pl),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_pl)
   );

   assign out_result   = XLEN'(out_pl.result);
   assign out_wdata    = XLEN'(out_pl.wdata);
   assign out_rd       = REGW'(out_pl.rd);
   assign out_regwrite = out_pl.regwrite;
   assign out_memread  = out_pl.memread;
   assign out_memwrite = out_pl.memwrite;
   assign out_funct3   = out_pl.funct3;

   assign fwd_en   = out_valid & out_pl.regwrite & (out_pl.rd != '0);
   assign fwd_rd   = out_rd;
   assign fwd_data = out_result;

`ifdef EX_MEM_MISALIGN_CHK_EN
   // Qualified by valid so a flush or reset never leaves a stale flag visible.
   assign out_misalign = out_valid & out_pl.misalign;
`endif

endmodule
